fifo_rd_stream: RTL and testbench

Read-side drain stage for the synchronous FIFO. It consumes words through the FIFO's show-ahead read port (`rd_data`/`rd_empty`/`read`) and presents them downstream as a registered valid/ready stream. It uses a 2-entry skid buffer so that `m_ready` has no combinational path back to the FIFO `read` strobe. It sits between any `sync_fifo` instance and a valid/ready consumer.

---
 rtl/fifo_rd_stream.sv | 120 ++++++++++++
 tb/tb_fifo_rd_stream.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: show-ahead FIFO port to a registered valid/ready stream via a 2-entry
// skid buffer. Define FIFO_RD_STREAM_STATS_EN to build the beat/stall statistics counters.
module fifo_rd_stream #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_rd_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_read,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [1:0]            occupancy,
    input  logic                  stats_clr,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  push;
    logic                  pop;

    // The read strobe never looks at m_ready; rst_n gating keeps the FIFO untouched in reset.
    assign push      = rst_n && !fifo_rd_empty && (state_q != StFull);
    assign fifo_read = push;
    assign m_valid   = (state_q != StEmpty);
    assign pop       = m_valid && m_ready;
    assign m_data    = head_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    state_d = StOne;
                    head_d  = fifo_rd_data;
                end
            end
            StOne: begin
                if (push && !pop) begin
                    state_d = StFull;
                    tail_d  = fifo_rd_data;
                end else if (pop && !push) begin
                    state_d = StEmpty;
                end else if (push && pop) begin
                    head_d = fifo_rd_data;
                end
            end
            StFull: begin
                if (pop) begin
                    state_d = StOne;
                    head_d  = tail_q;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        occupancy = 2'd0;
        unique case (state_q)
            StOne:   occupancy = 2'd1;
            StFull:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [CNT_WIDTH-1:0] beat_q;
    logic [CNT_WIDTH-1:0] stall_q;

    // Clear wins over a coincident increment; both counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q  <= '0;
            stall_q <= '0;
        end else if (stats_clr) begin
            beat_q  <= '0;
            stall_q <= '0;
        end else begin
            if (pop && (beat_q != '1)) begin
                beat_q <= beat_q + 1'b1;
            end
            if (m_valid && !m_ready && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign beat_count  = beat_q;
    assign stall_count = stall_q;
`else
    logic unused_stats_clr;

    assign unused_stats_clr = stats_clr;
    assign beat_count       = '0;
    assign stall_count      = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural show-ahead FIFO and an in-order scoreboard.
module tb_fifo_rd_stream;

    localparam int unsigned DW = 4;
    localparam int unsigned CW = 4;
`ifdef FIFO_RD_STREAM_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_rd_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_read;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b0;
    logic [1:0]    occupancy;
    logic          stats_clr = 1'b0;
    logic [CW-1:0] beat_count;
    logic [CW-1:0] stall_count;

    int n_checks = 0;
    int n_errs   = 0;
    int n_beats  = 0;

    logic [DW-1:0] mem [0:2047];
    logic [11:0]   wr_ptr = '0;
    logic [11:0]   rd_ptr = '0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_word;

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_rd_empty (fifo_rd_empty),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_read     (fifo_read),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .occupancy     (occupancy),
        .stats_clr     (stats_clr),
        .beat_count    (beat_count),
        .stall_count   (stall_count)
    );

    always #5 clk = ~clk;

    assign fifo_rd_empty = (rd_ptr == wr_ptr);
    assign fifo_rd_data  = mem[rd_ptr[10:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        mem[wr_ptr[10:0]] = d;
        wr_ptr = wr_ptr + 12'd1;
        exp_q.push_back(d);
    endtask

    task automatic drain(input int max);
        int k;
        m_ready = 1'b1;
        for (k = 0; k < max; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_valid) break;
        end
        if (k == max) check("drain_timeout", 32'd1, 32'd0);
        check("drain_left", exp_q.size(), 32'd0);
    endtask

    always @(posedge clk) begin
        if (fifo_read) begin
            check("read_while_empty", {31'd0, fifo_rd_empty}, 32'd0);
            rd_ptr <= rd_ptr + 12'd1;
        end
    end

    always @(posedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            n_beats++;
            if (exp_q.size() == 0) begin
                check("extra_beat", 32'd1, 32'd0);
            end else begin
                exp_word = exp_q.pop_front();
                check("order", {28'd0, m_data}, {28'd0, exp_word});
            end
        end
    end

    initial begin
        int base_beats;
        logic [11:0] base_rd;
        int written;

        // Reset with a non-empty FIFO: nothing may be read
        for (int i = 1; i <= 8; i++) push_word(4'(i));
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", {31'd0, m_valid}, 32'd0);
        check("rst_occ", {30'd0, occupancy}, 32'd0);
        check("rst_data", {28'd0, m_data}, 32'd0);
        check("rst_read", {31'd0, fifo_read}, 32'd0);
        check("rst_beat", {28'd0, beat_count}, 32'd0);
        check("rst_stall", {28'd0, stall_count}, 32'd0);

        // Streaming 1..8
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        #1;
        check("st_first_read", {31'd0, fifo_read}, 32'd1);
        check("st_first_valid", {31'd0, m_valid}, 32'd0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            #1;
            check("st_valid", {31'd0, m_valid}, 32'd1);
            check("st_data", {28'd0, m_data}, 32'(i));
            check("st_occ", {30'd0, occupancy}, 32'd1);
            check("st_read", {31'd0, fifo_read}, (i < 8) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        #1;
        check("st_end_valid", {31'd0, m_valid}, 32'd0);
        check("st_beats", n_beats, 32'd8);
        check("st_beat_count", {28'd0, beat_count}, StatsEn ? 32'd8 : 32'd0);

        // Backpressure with 3,5,7
        @(negedge clk);
        m_ready = 1'b0;
        push_word(4'h3);
        push_word(4'h5);
        push_word(4'h7);
        #1;
        check("bp_read0", {31'd0, fifo_read}, 32'd1);
        @(negedge clk);
        #1;
        check("bp_occ1", {30'd0, occupancy}, 32'd1);
        check("bp_data1", {28'd0, m_data}, 32'h3);
        @(negedge clk);
        #1;
        check("bp_occ2", {30'd0, occupancy}, 32'd2);
        check("bp_read_off", {31'd0, fifo_read}, 32'd0);
        check("bp_data2", {28'd0, m_data}, 32'h3);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("bp_hold_data", {28'd0, m_data}, 32'h3);
            check("bp_hold_occ", {30'd0, occupancy}, 32'd2);
            check("bp_hold_read", {31'd0, fifo_read}, 32'd0);
        end
        m_ready = 1'b1;
        #1;
        check("bp_release_read", {31'd0, fifo_read}, 32'd0);
        @(negedge clk);
        #1;
        check("bp_data_5", {28'd0, m_data}, 32'h5);
        check("bp_occ_after", {30'd0, occupancy}, 32'd1);
        check("bp_read_resume", {31'd0, fifo_read}, 32'd1);
        @(negedge clk);
        #1;
        check("bp_data_7", {28'd0, m_data}, 32'h7);
        check("bp_read_empty", {31'd0, fifo_read}, 32'd0);
        @(negedge clk);
        #1;
        check("bp_end_valid", {31'd0, m_valid}, 32'd0);
        check("bp_stall_count", {28'd0, stall_count}, StatsEn ? 32'd4 : 32'd0);
        check("bp_beat_count", {28'd0, beat_count}, StatsEn ? 32'd11 : 32'd0);

        // Clear, then an always-empty FIFO with toggling m_ready
        @(negedge clk);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        #1;
        check("clr_beat", {28'd0, beat_count}, 32'd0);
        check("clr_stall", {28'd0, stall_count}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            m_ready = i[0];
            #1;
            check("empty_read", {31'd0, fifo_read}, 32'd0);
            check("empty_valid", {31'd0, m_valid}, 32'd0);
        end
        check("empty_beat", {28'd0, beat_count}, 32'd0);
        check("empty_stall", {28'd0, stall_count}, 32'd0);

        // Reset with the buffer full: A,B discarded, C follows
        @(negedge clk);
        m_ready = 1'b0;
        base_rd = rd_ptr;
        push_word(4'hA);
        push_word(4'hB);
        push_word(4'hC);
        repeat (2) @(negedge clk);
        #1;
        check("mr_occ_full", {30'd0, occupancy}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_valid", {31'd0, m_valid}, 32'd0);
        check("mr_occ", {30'd0, occupancy}, 32'd0);
        check("mr_data", {28'd0, m_data}, 32'd0);
        check("mr_read", {31'd0, fifo_read}, 32'd0);
        check("mr_fifo_reads", {20'd0, rd_ptr - base_rd}, 32'd2);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        base_beats = n_beats;
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        #1;
        check("mr_resume_read", {31'd0, fifo_read}, 32'd1);
        drain(20);
        check("mr_beats", n_beats - base_beats, 32'd1);

        // Random m_ready and FIFO fill, 1000 words
        written    = 0;
        base_beats = n_beats;
        for (int c = 0; c < 6000 && written < 1000; c++) begin
            @(negedge clk);
            m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                push_word(4'($urandom_range(0, 15)));
                written++;
            end
        end
        check("rnd_written", written, 32'd1000);
        drain(2000);
        check("rnd_beats", n_beats - base_beats, 32'd1000);
        check("rnd_beat_sat", {28'd0, beat_count}, StatsEn ? 32'hF : 32'd0);

        // Clear coincident with a pop
        @(negedge clk);
        m_ready = 1'b1;
        push_word(4'h9);
        push_word(4'hA);
        push_word(4'hB);
        push_word(4'hC);
        @(negedge clk);
        #1;
        check("cp_data", {28'd0, m_data}, 32'h9);
        stats_clr = 1'b1;
        @(negedge clk);
        #1;
        check("cp_beat_clr", {28'd0, beat_count}, 32'd0);
        stats_clr = 1'b0;
        @(negedge clk);
        #1;
        check("cp_beat_inc", {28'd0, beat_count}, StatsEn ? 32'd1 : 32'd0);
        drain(20);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
